// File: rtl/master_nios2_qsys_0_ocimem_ctrl_if.sv
// Debug RAM port between the OCI memory controller (master) and the debug RAM (slave).
interface master_nios2_qsys_0_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic              ram_wr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport master (
    output ram_addr,
    output ram_rd,
    output ram_wr,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_rd,
    input  ram_wr,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/master_nios2_qsys_0_ocimem_ctrl.sv
// JTAG-driven controller for the Nios II debug RAM: address/control commands,
// single-word writes and reads, and the sticky monitor handshake flags.
module master_nios2_qsys_0_ocimem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [37:0]                            jdo,
  input  logic                                   take_action_ocimem_a,
  input  logic                                   take_action_ocimem_b,
  input  logic                                   take_no_action_ocimem_a,
  input  logic                                   monitor_set_ready,
  input  logic                                   monitor_set_error,
  input  logic                                   monitor_ack,
  master_nios2_qsys_0_ocimem_ctrl_if.master      ram,
  output logic [31:0]                            MonDReg,
  output logic                                   monitor_ready,
  output logic                                   monitor_error,
  output logic                                   monitor_go,
  output logic                                   resetrequest,
  output logic                                   busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_ISSUE = 2'd2,
    RD_CAP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rd_q;
  logic              wr_q;

  logic load_req;
  logic load_ok;
  logic accept_wr;
  logic accept_rd;
  logic drop_any;
  logic unused_jdo;

  assign unused_jdo = ^jdo[1:0];

  assign busy          = (state != IDLE);
  assign ram.ram_addr  = addr_q;
  assign ram.ram_rd    = rd_q;
  assign ram.ram_wr    = wr_q;
  assign ram.ram_wdata = wdata_q;

  // An address load in the same cycle as a b/no_action pulse wins the slot;
  // anything that cannot be accepted is dropped and flagged as an error.
  always_comb begin
    state_next = state;
    load_req   = take_action_ocimem_a & jdo[37];
    load_ok    = 1'b0;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    drop_any   = 1'b0;

    case (state)
      IDLE: begin
        load_ok = load_req;
        if (!load_req) begin
          if (take_action_ocimem_b) begin
            accept_wr  = 1'b1;
            state_next = WRITE;
          end else if (take_no_action_ocimem_a) begin
            accept_rd  = 1'b1;
            state_next = RD_ISSUE;
          end
        end
      end
      WRITE:    state_next = IDLE;
      RD_ISSUE: state_next = RD_CAP;
      RD_CAP:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    drop_any = (load_req & ~load_ok)
             | (take_action_ocimem_b & ~accept_wr)
             | (take_no_action_ocimem_a & ~accept_rd);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and strobes; strobes are registered so they line up with the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      MonDReg <= '0;
    end else begin
      rd_q <= accept_rd;
      wr_q <= accept_wr;
      if (accept_wr) begin
        wdata_q <= jdo[34:3];
      end
      if (load_ok) begin
        addr_q <= jdo[ADDR_W+1:2];
      end else if (state == WRITE || state == RD_CAP) begin
        addr_q <= addr_q + 1'b1;
      end
      if (state == RD_CAP) begin
        MonDReg <= ram.ram_rdata;
      end
    end
  end

  // Sticky monitor flags: a set always beats a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
      resetrequest  <= 1'b0;
    end else begin
      if (monitor_set_ready) begin
        monitor_ready <= 1'b1;
      end else if (take_action_ocimem_a && jdo[36]) begin
        monitor_ready <= 1'b0;
      end

      if (monitor_set_error || drop_any) begin
        monitor_error <= 1'b1;
      end else if (take_action_ocimem_a && jdo[35]) begin
        monitor_error <= 1'b0;
      end

      if (take_action_ocimem_a && jdo[34]) begin
        monitor_go <= 1'b1;
      end else if (monitor_ack) begin
        monitor_go <= 1'b0;
      end

      if (take_action_ocimem_a) begin
        resetrequest <= jdo[33];
      end
    end
  end

endmodule

// File: tb/tb_master_nios2_qsys_0_ocimem_ctrl.sv
// Directed bench for the OCI memory controller; the bench also plays the debug RAM
// (one-cycle read latency, unwritten words read back as 0xA50000xx).
module tb_master_nios2_qsys_0_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic        monitor_set_ready;
  logic        monitor_set_error;
  logic        monitor_ack;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;
  logic        monitor_go;
  logic        resetrequest;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0]  mem [0:255];
  logic [255:0] vld;

  master_nios2_qsys_0_ocimem_ctrl_if #(.ADDR_W(8)) ram_bus ();

  master_nios2_qsys_0_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .monitor_set_ready       (monitor_set_ready),
    .monitor_set_error       (monitor_set_error),
    .monitor_ack             (monitor_ack),
    .ram                     (ram_bus.master),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go),
    .resetrequest            (resetrequest),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  // Debug RAM model: registered read, so data is valid the cycle after ram_rd.
  always @(posedge clk) begin
    if (!reset_n) begin
      vld <= '0;
    end else if (ram_bus.ram_wr) begin
      mem[ram_bus.ram_addr] <= ram_bus.ram_wdata;
      vld[ram_bus.ram_addr] <= 1'b1;
    end
    if (ram_bus.ram_rd) begin
      ram_bus.ram_rdata <= vld[ram_bus.ram_addr] ? mem[ram_bus.ram_addr]
                                                 : {24'hA50000, ram_bus.ram_addr};
    end
  end

  function automatic logic [37:0] ld(input logic [7:0] a);
    return (38'd1 << 37) | ({30'd0, a} << 2);
  endfunction

  function automatic logic [37:0] wd(input logic [31:0] d);
    return {6'd0, d} << 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of command pulses, then return one cycle later with inputs idle.
  task automatic applyStimulus(input logic a, input logic b, input logic na, input logic [37:0] j);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = na;
    jdo                     = j;
    step();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo                     = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    monitor_set_ready = 1'b0;
    monitor_set_error = 1'b0;
    monitor_ack = 1'b0;
    step();
    step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_addr", 32'(ram_bus.ram_addr), 32'd0);
    checkOutput("rst_mondreg", MonDReg, 32'd0);
    checkOutput("rst_wdata", ram_bus.ram_wdata, 32'd0);
    checkOutput("rst_strobes", {30'd0, ram_bus.ram_rd, ram_bus.ram_wr}, 32'd0);
    checkOutput("rst_flags", {28'd0, monitor_ready, monitor_error, monitor_go, resetrequest}, 32'd0);
    reset_n = 1'b1;
    step();

    // Load address then write one word
    applyStimulus(1, 0, 0, ld(8'h10));
    checkOutput("ld_addr", 32'(ram_bus.ram_addr), 32'h10);
    checkOutput("ld_busy", 32'(busy), 32'd0);
    applyStimulus(0, 1, 0, wd(32'hDEADBEEF));
    checkOutput("wr_strobe", 32'(ram_bus.ram_wr), 32'd1);
    checkOutput("wr_rd_low", 32'(ram_bus.ram_rd), 32'd0);
    checkOutput("wr_addr", 32'(ram_bus.ram_addr), 32'h10);
    checkOutput("wr_data", ram_bus.ram_wdata, 32'hDEADBEEF);
    checkOutput("wr_busy", 32'(busy), 32'd1);
    step();
    checkOutput("wr_done_strobe", 32'(ram_bus.ram_wr), 32'd0);
    checkOutput("wr_done_addr", 32'(ram_bus.ram_addr), 32'h11);
    checkOutput("wr_done_busy", 32'(busy), 32'd0);

    // Read back the same word
    applyStimulus(1, 0, 0, ld(8'h10));
    applyStimulus(0, 0, 1, '0);
    checkOutput("rd_strobe", 32'(ram_bus.ram_rd), 32'd1);
    checkOutput("rd_busy1", 32'(busy), 32'd1);
    checkOutput("rd_addr", 32'(ram_bus.ram_addr), 32'h10);
    step();
    checkOutput("rd_strobe_off", 32'(ram_bus.ram_rd), 32'd0);
    checkOutput("rd_busy2", 32'(busy), 32'd1);
    checkOutput("rd_mon_early", MonDReg, 32'd0);
    step();
    checkOutput("rd_mondreg", MonDReg, 32'hDEADBEEF);
    checkOutput("rd_addr_inc", 32'(ram_bus.ram_addr), 32'h11);
    checkOutput("rd_busy_done", 32'(busy), 32'd0);
    checkOutput("rd_no_err", 32'(monitor_error), 32'd0);

    // Address wrap on write at 0xFF
    applyStimulus(1, 0, 0, ld(8'hFF));
    applyStimulus(0, 1, 0, wd(32'h12345678));
    checkOutput("wrap_wr_addr", 32'(ram_bus.ram_addr), 32'hFF);
    step();
    checkOutput("wrap_addr", 32'(ram_bus.ram_addr), 32'h00);
    checkOutput("wrap_no_err", 32'(monitor_error), 32'd0);

    // Write pulse while a read is in flight is dropped
    applyStimulus(0, 0, 1, '0);
    applyStimulus(0, 1, 0, wd(32'h55));
    checkOutput("drop_wr_strobe", 32'(ram_bus.ram_wr), 32'd0);
    checkOutput("drop_err", 32'(monitor_error), 32'd1);
    step();
    checkOutput("drop_wr_strobe2", 32'(ram_bus.ram_wr), 32'd0);
    checkOutput("drop_rd_data", MonDReg, 32'hA5000000);
    checkOutput("drop_addr", 32'(ram_bus.ram_addr), 32'h01);

    // Error set and clear in the same cycle: set wins; then clear alone
    monitor_set_error = 1'b1;
    applyStimulus(1, 0, 0, 38'd1 << 35);
    monitor_set_error = 1'b0;
    checkOutput("err_set_wins", 32'(monitor_error), 32'd1);
    applyStimulus(1, 0, 0, 38'd1 << 35);
    checkOutput("err_clear", 32'(monitor_error), 32'd0);

    // monitor_go set with simultaneous ack, then ack alone
    monitor_ack = 1'b1;
    applyStimulus(1, 0, 0, 38'd1 << 34);
    checkOutput("go_set_wins", 32'(monitor_go), 32'd1);
    step();
    monitor_ack = 1'b0;
    checkOutput("go_ack", 32'(monitor_go), 32'd0);

    // Ready flag
    monitor_set_ready = 1'b1;
    step();
    checkOutput("ready_set", 32'(monitor_ready), 32'd1);
    applyStimulus(1, 0, 0, 38'd1 << 36);
    monitor_set_ready = 1'b0;
    checkOutput("ready_set_wins", 32'(monitor_ready), 32'd1);
    applyStimulus(1, 0, 0, 38'd1 << 36);
    checkOutput("ready_clear", 32'(monitor_ready), 32'd0);

    // Reset request level follows jdo[33] on each a command
    applyStimulus(1, 0, 0, 38'd1 << 33);
    checkOutput("rstreq_set", 32'(resetrequest), 32'd1);
    applyStimulus(1, 0, 0, '0);
    checkOutput("rstreq_clr", 32'(resetrequest), 32'd0);

    // Priority: address load blocks b
    applyStimulus(1, 1, 0, ld(8'h20));
    checkOutput("prio_ld_addr", 32'(ram_bus.ram_addr), 32'h20);
    checkOutput("prio_ld_no_wr", 32'(ram_bus.ram_wr), 32'd0);
    checkOutput("prio_ld_busy", 32'(busy), 32'd0);
    checkOutput("prio_ld_err", 32'(monitor_error), 32'd1);
    applyStimulus(1, 0, 0, 38'd1 << 35);
    checkOutput("prio_err_clr", 32'(monitor_error), 32'd0);

    // Priority: a without load, b wins over no_action
    applyStimulus(1, 1, 1, wd(32'hCAFE));
    checkOutput("prio_b_wr", 32'(ram_bus.ram_wr), 32'd1);
    checkOutput("prio_b_no_rd", 32'(ram_bus.ram_rd), 32'd0);
    checkOutput("prio_b_data", ram_bus.ram_wdata, 32'hCAFE);
    checkOutput("prio_b_err", 32'(monitor_error), 32'd1);
    step();
    checkOutput("prio_b_addr", 32'(ram_bus.ram_addr), 32'h21);

    // Address load while busy is dropped
    applyStimulus(1, 0, 0, 38'd1 << 35);
    applyStimulus(0, 0, 1, '0);
    applyStimulus(1, 0, 0, ld(8'h40));
    checkOutput("busy_ld_addr", 32'(ram_bus.ram_addr), 32'h21);
    checkOutput("busy_ld_err", 32'(monitor_error), 32'd1);
    step();
    checkOutput("busy_ld_addr2", 32'(ram_bus.ram_addr), 32'h22);
    checkOutput("busy_ld_data", MonDReg, 32'hA5000021);

    // Reset in RD_ISSUE aborts the read and clears all flags
    monitor_set_ready = 1'b1;
    applyStimulus(1, 0, 0, (38'd1 << 34) | (38'd1 << 33));
    monitor_set_ready = 1'b0;
    checkOutput("pre_rst_go", 32'(monitor_go), 32'd1);
    applyStimulus(0, 0, 1, '0);
    checkOutput("pre_rst_rd", 32'(ram_bus.ram_rd), 32'd1);
    reset_n = 1'b0;
    step();
    checkOutput("abort_rd", 32'(ram_bus.ram_rd), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_mondreg", MonDReg, 32'd0);
    checkOutput("abort_addr", 32'(ram_bus.ram_addr), 32'd0);
    checkOutput("abort_flags", {28'd0, monitor_ready, monitor_error, monitor_go, resetrequest}, 32'd0);
    applyStimulus(1, 0, 0, ld(8'h33));
    checkOutput("rst_ignore_ld", 32'(ram_bus.ram_addr), 32'd0);
    reset_n = 1'b1;
    step();
    step();
    checkOutput("post_rst_mondreg", MonDReg, 32'd0);
    checkOutput("post_rst_addr", 32'(ram_bus.ram_addr), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
